uart_char_rx: RTL and testbench

- Bit-serial character receiver sitting directly upstream of the identifier-recognising FSM.
- Deserialises an asynchronous 8N1 line (start bit, 8 data bits LSB first, one stop bit) into the 8-bit `char` bus the FSM samples every clock.
- Holds the last good character stable between frames, so the downstream FSM sees a steady code.
- Flags each new character with a one-cycle strobe and reports framing errors.

---
 rtl/uart_char_rx.sv | 132 +++++++++++++
 tb/tb_uart_char_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_char_rx.sv
// 8N1 serial character receiver: two-flop synchroniser, mid-bit sampling FSM,
// registered char/strobe outputs that hold the last good character between frames.
module uart_char_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       char_d;
  logic             valid_d, ferr_d, busy_d;
  logic             rxd_m, rxd_s;

  // Synchroniser presets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      char       <= '0;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      char       <= char_d;
      char_valid <= valid_d;
      frame_err  <= ferr_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    char_d  = char;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      // Re-check the start bit at its centre to reject glitches
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxd_s;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = 3'(bit_q + 1'b1);
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            char_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      // Wait out a held-low line so it never looks like a new start bit
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_char_rx.sv
// Bench for uart_char_rx: directed scenarios plus random 8N1 traffic checked
// against a queue of expected characters and a held-value model.
module tb_uart_char_rx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] char;
  logic       char_valid, frame_err, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int exp_valid = 0;
  int exp_ferr  = 0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;

  uart_char_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .char(char), .char_valid(char_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every strobe must deliver the next expected character; otherwise char holds
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("valid_and_ferr", 32'(char_valid & frame_err), 32'd0);
      if (char_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          held = exp_q.pop_front();
          check("char_on_strobe", 32'(char), 32'(held));
        end
      end else begin
        check("char_hold", 32'(char), 32'(held));
      end
      if (frame_err) n_ferr++;
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    if (stop) begin
      exp_q.push_back(d);
      exp_valid++;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    held  = 8'h00;
    exp_q.delete();
    #1;
    check("rst_char", 32'(char), 32'h00);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_valid_cnt"}, 32'(n_valid), 32'(exp_valid));
    check({tag, "_ferr_cnt"}, 32'(n_ferr), 32'(exp_ferr));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       bad;
    int         gap;

    mon_en = 1'b1;
    apply_reset();

    // Idle line after reset
    idle(20);
    check("idle_char", 32'(char), 32'h00);
    check("idle_busy", 32'(busy), 32'd0);
    check_counts("idle");

    // Single character
    send_frame(8'h61, 1'b1);
    idle(3 * CPB);
    check("single_char", 32'(char), 32'h61);
    check_counts("single");

    // Back-to-back frames with no idle gap
    send_frame(8'h61, 1'b1);
    send_frame(8'h30, 1'b1);
    send_frame(8'h31, 1'b1);
    idle(50);
    check("b2b_char", 32'(char), 32'h31);
    check_counts("b2b");

    // One-clock glitch on the line
    rxd = 1'b0;
    @(negedge clk);
    idle(20);
    check("glitch_char", 32'(char), 32'h31);
    check("glitch_busy", 32'(busy), 32'd0);
    check_counts("glitch");

    // Framing error, held-low break, then recovery
    send_frame(8'h30, 1'b0);
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    check("break_char", 32'(char), 32'h31);
    idle(2 * CPB);
    check("break_exit_busy", 32'(busy), 32'd0);
    send_frame(8'h61, 1'b1);
    idle(3 * CPB);
    check("after_break_char", 32'(char), 32'h61);
    check_counts("break");

    // Reset during data bit 4 of a frame
    d = 8'h5a;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxd = d[4];
    @(negedge clk);
    apply_reset();
    idle(20);
    check("post_rst_char", 32'(char), 32'h00);
    send_frame(8'h61, 1'b1);
    idle(3 * CPB);
    check("post_rst_frame", 32'(char), 32'h61);
    check_counts("midreset");

    // Random traffic with occasional framing errors and short gaps
    for (int k = 0; k < 40; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(d, !bad);
      gap = bad ? (1 + $urandom_range(0, 2)) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    idle(4 * CPB);
    check("rand_busy", 32'(busy), 32'd0);
    check_counts("rand");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
